// File: rtl/uart_pkg.sv
// Shared UART encodings: state values seen on the debug GPIO and frame constants.
// The receiver uses the same package so both ends report identical state codes.
package uart_pkg;

    localparam logic [2:0] SM_IDLE    = 3'd0;
    localparam logic [2:0] SM_START   = 3'd1;
    localparam logic [2:0] SM_DATA    = 3'd2;
    localparam logic [2:0] SM_STOP    = 3'd3;
    localparam logic [2:0] SM_CLEANUP = 3'd4;

    localparam int DATA_BITS = 8;

    typedef enum logic [2:0] {
        IDLE    = SM_IDLE,
        START   = SM_START,
        DATA    = SM_DATA,
        STOP    = SM_STOP,
        CLEANUP = SM_CLEANUP
    } tx_state_e;

endpackage

// File: rtl/uart_tx_byte_fifo.sv
// Synchronous byte FIFO with occupancy count. Writes while full are dropped.
// Reads are only issued by the transmitter when the FIFO is non-empty.
module uart_tx_byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr_en,
    input  logic [DATA_BITS-1:0]       wr_data,
    input  logic                       rd_en,
    output logic [DATA_BITS-1:0]       rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [DATA_BITS-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 push;
    logic                 pop;

    // Pointer, storage and count update; pointers wrap naturally at the power-of-two depth.
    always_comb begin
        push     = wr_en && (count_q != FULL_CNT);
        pop      = rd_en && (count_q != '0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset empties the queue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == FULL_CNT);

endmodule

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed from a small byte FIFO. Idle line is high.
// All outputs toward the pin and debug GPIO are registered.
//
// state   | meaning
// IDLE    | line high, pop next byte when the FIFO has one
// START   | start bit (low) for one bit time
// DATA    | data bits, LSB first, one bit time each
// STOP    | stop bit (high) for one bit time
// CLEANUP | single cycle before IDLE; raises the done pulse
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          i_Clock,
    input  logic                          i_Reset_n,
    input  logic                          i_TX_DV,
    input  logic [7:0]                    i_TX_Byte,
    output logic                          o_TX_Ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
    output logic                          o_TX_Active,
    output logic                          o_TX_Serial,
    output logic                          o_TX_Done,
    output logic [2:0]                    o_SM_Main
);

    localparam int TIMER_W = $clog2(CLKS_PER_BIT);
    localparam logic [TIMER_W-1:0] BIT_LAST = TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]         IDX_LAST = 3'(DATA_BITS - 1);

    tx_state_e              state_q, state_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;
    logic [2:0]             idx_q, idx_d;
    logic [DATA_BITS-1:0]   shift_q, shift_d;
    logic                   serial_q, serial_d;
    logic                   active_q, active_d;
    logic                   done_q, done_d;

    logic                   fifo_pop;
    logic [DATA_BITS-1:0]   fifo_rd_data;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic                   fifo_full;

    uart_tx_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_Clock),
        .rst_n   (i_Reset_n),
        .wr_en   (i_TX_DV),
        .wr_data (i_TX_Byte),
        .rd_en   (fifo_pop),
        .rd_data (fifo_rd_data),
        .count   (fifo_count),
        .full    (fifo_full)
    );

    // Next-state, bit timer and line level; line outputs are computed from the next state so they register in step with it.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_count != '0) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rd_data;
                    timer_d  = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (timer_q == BIT_LAST) begin
                    timer_d = '0;
                    state_d = CLEANUP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            CLEANUP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        case (state_d)
            START:   serial_d = 1'b0;
            DATA:    serial_d = shift_d[idx_d];
            default: serial_d = 1'b1;
        endcase
        active_d = (state_d == START) || (state_d == DATA) || (state_d == STOP);
        done_d   = (state_q == CLEANUP);
    end

    // Transmitter registers; reset aborts any frame and returns the line high.
    always_ff @(posedge i_Clock or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            serial_q <= serial_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign o_TX_Ready   = !fifo_full;
    assign o_FIFO_Count = fifo_count;
    assign o_TX_Active  = active_q;
    assign o_TX_Serial  = serial_q;
    assign o_TX_Done    = done_q;
    assign o_SM_Main    = state_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// A line monitor decodes frames off o_TX_Serial and timestamps start bits and done pulses.
module tb_uart_tx_fifo;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv = 1'b0;
    logic [7:0] tx_byte = 8'h00;
    logic       ready;
    logic [2:0] count;
    logic       active;
    logic       serial;
    logic       done;
    logic [2:0] sm;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] rx_q [$];
    int         rx_t [$];
    int         done_t [$];
    int         frame_err = 0;
    logic       mon_busy = 1'b0;
    int         mon_cnt = 0;
    int         mon_start = 0;
    logic [9:0] mon_bits = '0;
    logic       mon_prev = 1'b1;

    uart_tx_fifo #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .i_Clock      (clk),
        .i_Reset_n    (rst_n),
        .i_TX_DV      (dv),
        .i_TX_Byte    (tx_byte),
        .o_TX_Ready   (ready),
        .o_FIFO_Count (count),
        .o_TX_Active  (active),
        .o_TX_Serial  (serial),
        .o_TX_Done    (done),
        .o_SM_Main    (sm)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Line monitor: frames sampled mid-bit, start bit and done pulses timestamped in cycles.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mon_busy = 1'b0;
                mon_prev = 1'b1;
            end else begin
                if (done) done_t.push_back(cyc);
                if (mon_busy) begin
                    mon_cnt++;
                    if (mon_cnt % CPB == CPB / 2) mon_bits[mon_cnt / CPB] = serial;
                    if (mon_cnt == 9 * CPB + CPB / 2) begin
                        mon_busy = 1'b0;
                        if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1) frame_err++;
                        rx_q.push_back(mon_bits[8:1]);
                        rx_t.push_back(mon_start);
                    end
                end else if (mon_prev && !serial) begin
                    mon_busy  = 1'b1;
                    mon_cnt   = 0;
                    mon_start = cyc;
                end
                mon_prev = serial;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic clear_mon();
        rx_q.delete();
        rx_t.delete();
        done_t.delete();
        frame_err = 0;
    endtask

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        dv = 1'b1;
        tx_byte = b;
        @(posedge clk);
        #1 dv = 1'b0;
    endtask

    task automatic write_burst(input logic [7:0] bytes [$]);
        @(negedge clk);
        dv = 1'b1;
        foreach (bytes[i]) begin
            tx_byte = bytes[i];
            @(posedge clk);
            #1;
        end
        dv = 1'b0;
    endtask

    task automatic wait_quiet(input string tag, input int max_cyc);
        int n = 0;
        while (!(sm == 3'd0 && count == 3'd0 && !mon_busy && serial) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check(tag, 32'(n >= max_cyc), 32'd0);
    endtask

    task automatic check_frames(input string tag, input logic [7:0] exp [$]);
        int bad = 0;
        check({tag, "_nframes"}, 32'(rx_q.size()), 32'(exp.size()));
        foreach (exp[i]) begin
            if (i >= rx_q.size() || rx_q[i] !== exp[i]) bad++;
        end
        check({tag, "_bytes"}, 32'(bad), 32'd0);
        check({tag, "_framing"}, 32'(frame_err), 32'd0);
    endtask

    initial begin
        logic [9:0] frame;
        logic [7:0] exp_q [$];
        int err;
        int n;
        int k;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_serial", 32'(serial), 32'd1);
        check("rst_active", 32'(active), 32'd0);
        check("rst_done",   32'(done),   32'd0);
        check("rst_sm",     32'(sm),     32'd0);
        check("rst_ready",  32'(ready),  32'd1);
        check("rst_count",  32'(count),  32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: single byte 0xA5, exact waveform and done timing
        clear_mon();
        write_byte(8'hA5);
        @(negedge clk);
        check("t1_count_after_wr", 32'(count), 32'd1);
        check("t1_serial_pre",     32'(serial), 32'd1);
        frame = {1'b1, 8'hA5, 1'b0};
        err = 0;
        for (int i = 0; i < 10 * CPB; i++) begin
            @(negedge clk);
            if (serial !== frame[i / CPB]) err++;
            if (i == 0) begin
                check("t1_sm_start", 32'(sm), 32'd1);
                check("t1_active",   32'(active), 32'd1);
                check("t1_count_popped", 32'(count), 32'd0);
            end
            if (i == 2 * CPB) check("t1_sm_data", 32'(sm), 32'd2);
        end
        check("t1_wave", 32'(err), 32'd0);
        @(negedge clk);
        check("t1_sm_cleanup", 32'(sm), 32'd4);
        wait_quiet("t1_timeout", 200);
        exp_q = '{8'hA5};
        check_frames("t1", exp_q);
        check("t1_done_count", 32'(done_t.size()), 32'd1);
        if (done_t.size() > 0 && rx_t.size() > 0)
            check("t1_done_delay", 32'(done_t[0] - rx_t[0]), 32'd41);

        // 2: five back-to-back writes, ready drops at count 4, 42-cycle spacing
        clear_mon();
        exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        write_burst(exp_q);
        @(negedge clk);
        check("t2_count_full", 32'(count), 32'd4);
        check("t2_ready_low",  32'(ready), 32'd0);
        wait_quiet("t2_timeout", 1000);
        check_frames("t2", exp_q);
        err = 0;
        for (int i = 1; i < rx_t.size(); i++) begin
            if (rx_t[i] - rx_t[i-1] != 10 * CPB + 2) err++;
        end
        check("t2_spacing", 32'(err), 32'd0);
        check("t2_done_count", 32'(done_t.size()), 32'd5);

        // 3: hold 0xFF while full, including across the pop edge
        clear_mon();
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};
        write_burst(exp_q);
        @(negedge clk);
        dv = 1'b1;
        tx_byte = 8'hFF;
        n = 0;
        while (count == 3'd4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        dv = 1'b0;
        check("t3_hold_timeout", 32'(n >= 200), 32'd0);
        check("t3_count_after_pop", 32'(count), 32'd3);
        wait_quiet("t3_timeout", 1000);
        check_frames("t3", exp_q);

        // 4: reset in the middle of DATA of 0x3C with 2 queued
        clear_mon();
        exp_q = '{8'h3C, 8'h41, 8'h42};
        write_burst(exp_q);
        n = 0;
        while (sm != 3'd2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t4_reach_data", 32'(n >= 50), 32'd0);
        repeat (2 * CPB) @(negedge clk);
        check("t4_count_pre", 32'(count), 32'd2);
        rst_n = 1'b0;
        #1;
        check("t4_serial", 32'(serial), 32'd1);
        check("t4_sm",     32'(sm),     32'd0);
        check("t4_count",  32'(count),  32'd0);
        check("t4_active", 32'(active), 32'd0);
        check("t4_ready",  32'(ready),  32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (150) @(negedge clk);
        check("t4_no_frames", 32'(rx_q.size()), 32'd0);
        check("t4_no_done",   32'(done_t.size()), 32'd0);
        check("t4_idle_sm",   32'(sm), 32'd0);

        // 5: random bytes with ready handshake, decoded by the line monitor
        clear_mon();
        exp_q.delete();
        for (int i = 0; i < 16; i++) exp_q.push_back(8'($urandom_range(0, 255)));
        k = 0;
        n = 0;
        while (k < 16 && n < 5000) begin
            @(negedge clk);
            n++;
            if (ready) begin
                dv = 1'b1;
                tx_byte = exp_q[k];
                @(posedge clk);
                #1 dv = 1'b0;
                k++;
            end
        end
        check("t5_write_timeout", 32'(n >= 5000), 32'd0);
        wait_quiet("t5_timeout", 1000);
        check_frames("t5", exp_q);

        // 6: write on the same edge as the IDLE pop with count=1
        clear_mon();
        exp_q = '{8'h5A, 8'hC3};
        write_burst(exp_q);
        @(negedge clk);
        check("t6_count_same_edge", 32'(count), 32'd1);
        wait_quiet("t6_timeout", 500);
        check_frames("t6", exp_q);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
